// File: rtl/map_query_arbiter_pkg.sv
// Shared map definitions: tile codes, requester indices, arbiter states and the
// walkable-tile test used by the arbiter and by the player/monster movers.
package map_query_arbiter_pkg;

    localparam int TILE_W = 3;

    localparam logic [TILE_W-1:0] MAP_ROAD0  = 3'b000;
    localparam logic [TILE_W-1:0] MAP_ROAD1  = 3'b001;
    localparam logic [TILE_W-1:0] MAP_WALL   = 3'b010;
    localparam logic [TILE_W-1:0] MAP_STAIRS = 3'b011;

    localparam int REQ_PLAYER   = 0;
    localparam int REQ_MONSTER0 = 1;
    localparam int REQ_MONSTER1 = 2;
    localparam int REQ_MONSTER2 = 3;
    localparam int REQ_MONSTER3 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    function automatic logic tile_walkable(input logic [TILE_W-1:0] tile);
        return (tile == MAP_ROAD0) || (tile == MAP_ROAD1) || (tile == MAP_STAIRS);
    endfunction

endpackage

// File: rtl/map_query_arbiter_if.sv
// Requester and map-port signals of the map query arbiter.
// slave = the arbiter; master = the movers plus the map ROM wrapper.
interface map_query_arbiter_if #(
    parameter int N_REQ   = 5,
    parameter int COORD_W = 10
);
    import map_query_arbiter_pkg::*;

    // Handshake: req is a level held by each requester; gnt is a one-cycle
    // pulse after which req_r/req_c may change; rsp_valid is a one-cycle pulse
    // marking rsp_type/rsp_walkable for exactly one requester.
    logic [N_REQ-1:0]         req;
    logic [N_REQ*COORD_W-1:0] req_r;
    logic [N_REQ*COORD_W-1:0] req_c;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_valid;
    logic [TILE_W-1:0]        rsp_type;
    logic                     rsp_walkable;
    logic [COORD_W-1:0]       map_r;
    logic [COORD_W-1:0]       map_c;
    logic                     map_rd_en;
    logic [TILE_W-1:0]        map_type;
    logic                     busy;

    modport slave (
        input  req, req_r, req_c, map_type,
        output gnt, rsp_valid, rsp_type, rsp_walkable, map_r, map_c, map_rd_en, busy
    );

    modport master (
        output req, req_r, req_c, map_type,
        input  gnt, rsp_valid, rsp_type, rsp_walkable, map_r, map_c, map_rd_en, busy
    );

endinterface

// File: rtl/map_query_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit scanning from i_rr_ptr
// upward, wrapping at N_REQ.
module map_query_arbiter_rr_pick #(
    parameter int N_REQ = 5,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any_req
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan farthest-first so the candidate nearest the pointer is written last.
    always_comb begin
        o_winner  = '0;
        o_any_req = |i_req;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (i_req[w_idx]) begin
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/map_query_arbiter.sv
// Shares one map-lookup port between the player and four monsters: round-robin
// selection, one read per query, tile type and walkable flag to the winner only.
module map_query_arbiter
    import map_query_arbiter_pkg::*;
#(
    parameter int N_REQ   = 5,
    parameter int MAP_LAT = 1,
    parameter int COORD_W = 10
) (
    input  logic               clk_13,
    input  logic               rst,
    map_query_arbiter_if.slave bus,
    output arb_state_e         o_dbg_state
);

    localparam int         IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0] CNT_INIT = (MAP_LAT > 0) ? 2'(MAP_LAT - 1) : 2'd0;

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [1:0]         r_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [TILE_W-1:0]  r_rsp_type;
    logic               r_rsp_walkable;
    logic [COORD_W-1:0] r_map_r;
    logic [COORD_W-1:0] r_map_c;
    logic               r_map_rd_en;
    logic               r_busy;

    logic [IDX_W-1:0]   w_win;
    logic               w_any;
    logic [N_REQ-1:0]   w_win_oh;
    logic [N_REQ-1:0]   w_sel_oh;

    map_query_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (bus.req),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_win),
        .o_any_req (w_any)
    );

    assign w_win_oh = N_REQ'(1) << w_win;
    assign w_sel_oh = N_REQ'(1) << r_sel;

    always_ff @(posedge clk_13 or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_sel          <= '0;
            r_rr_ptr       <= IDX_W'(REQ_PLAYER);
            r_cnt          <= '0;
            r_gnt          <= '0;
            r_rsp_valid    <= '0;
            r_rsp_type     <= '0;
            r_rsp_walkable <= 1'b0;
            r_map_r        <= '0;
            r_map_c        <= '0;
            r_map_rd_en    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel       <= w_win;
                        r_map_r     <= bus.req_r[w_win*COORD_W +: COORD_W];
                        r_map_c     <= bus.req_c[w_win*COORD_W +: COORD_W];
                        r_gnt       <= w_win_oh;
                        r_map_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_gnt       <= '0;
                    r_map_rd_en <= 1'b0;
                    // A zero-latency map answers in the same cycle as the strobe.
                    if (MAP_LAT == 0) begin
                        r_rsp_type     <= bus.map_type;
                        r_rsp_walkable <= tile_walkable(bus.map_type);
                        r_rsp_valid    <= w_sel_oh;
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt   <= CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else begin
                        r_rsp_type     <= bus.map_type;
                        r_rsp_walkable <= tile_walkable(bus.map_type);
                        r_rsp_valid    <= w_sel_oh;
                        r_state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= '0;
                    r_rr_ptr    <= (r_sel == IDX_W'(N_REQ - 1)) ? '0 : r_sel + 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_type     = r_rsp_type;
    assign bus.rsp_walkable = r_rsp_walkable;
    assign bus.map_r        = r_map_r;
    assign bus.map_c        = r_map_c;
    assign bus.map_rd_en    = r_map_rd_en;
    assign bus.busy         = r_busy;
    assign o_dbg_state      = r_state;

endmodule

// File: doc/map_query_arbiter.md
Name: map_query_arbiter

Overview:
- Shares the single map-lookup port (row/col in, 3-bit tile type out) between the player and the four monsters.
- Each requester posts a target tile. The block arbitrates round-robin, drives the map port, waits the map read latency, and returns the tile type plus a walkable flag to the winning requester only.
- Sits between the player/monster movement FSMs and the map ROM wrapper. It replaces the direct dest_r/dest_c/dest_type wiring from each mover.

Parameters:
- N_REQ, 5, number of requesters; index 0 = player, 1..4 = monster0..3.
- MAP_LAT, 1, map read latency in clk_13 cycles from the map_rd_en cycle to a valid map_type; legal range 0..3.
- COORD_W, 10, width of row and column coordinates.

Ports:
- clk_13  in  1  system clock, same as the pushbutton debounce clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester query request, level.
- req_r  in  N_REQ*COORD_W  flattened target rows; requester i at bits [i*COORD_W +: COORD_W].
- req_c  in  N_REQ*COORD_W  flattened target columns, same packing as req_r.
- gnt  out  N_REQ  one-hot, 1-cycle pulse; coordinates latched, requester may change req_r/req_c.
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse; rsp_type and rsp_walkable valid for that requester.
- rsp_type  out  3  tile type of the last completed query.
- rsp_walkable  out  1  1 when rsp_type is ROAD0 (000), ROAD1 (001) or STAIRS (011).
- map_r  out  COORD_W  row to the map port.
- map_c  out  COORD_W  column to the map port.
- map_rd_en  out  1  1-cycle read strobe to the map port.
- map_type  in  3  tile type from the map port, valid MAP_LAT cycles after map_rd_en.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - Reset is asynchronous on rst and overrides everything, including mid-transaction.
  - State = IDLE, rr_ptr = 0, wait counter = 0.
  - gnt, rsp_valid, map_rd_en, busy = 0; map_r, map_c, rsp_type = 0; rsp_walkable = 0.
  - A transaction interrupted by reset produces no rsp_valid.
- States: IDLE -> READ -> WAIT (skipped when MAP_LAT = 0) -> RESP -> IDLE.
- IDLE, cycle T:
  - If req != 0, winner w = first set bit of req scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Latch sel = w, map_r <= req_r[w], map_c <= req_c[w]; go to READ.
  - If req == 0, stay in IDLE.
- READ, cycle T+1:
  - gnt[sel] = 1 and map_rd_en = 1, both for this cycle only.
  - If MAP_LAT = 0: capture map_type this cycle and go to RESP.
  - Otherwise load the wait counter with MAP_LAT-1 and go to WAIT.
- WAIT:
  - While the counter != 0, decrement it.
  - When the counter == 0, i.e. at cycle T+1+MAP_LAT, capture rsp_type <= map_type, compute rsp_walkable, and go to RESP.
- RESP, cycle T+2+MAP_LAT:
  - rsp_valid[sel] = 1 for one cycle.
  - rr_ptr <= (sel == N_REQ-1) ? 0 : sel+1; go to IDLE.
- Latency: request sampled at T gives rsp_valid at T+2+MAP_LAT. Throughput is one query per MAP_LAT+3 cycles.
- Held outputs:
  - rsp_type and rsp_walkable hold their values until the next capture.
  - map_r and map_c hold until the next selection.
- Request timing:
  - Requests are sampled only in IDLE; req changes in other states are ignored.
  - A requester dropping req after selection still receives its rsp_valid.
  - req held high after rsp_valid counts as a new request and is re-arbitrated.
- Fairness: a continuously asserted request is served within N_REQ transactions.
- Simultaneous requests: exactly one winner per selection; no response is ever broadcast to more than one requester.
- Coordinates are passed through unchecked. Out-of-range handling belongs to the map wrapper.

Decomposition:
- Shared package, also used by the player and monster movers:
  - MAP_WALL, MAP_ROAD0, MAP_ROAD1, MAP_STAIRS tile codes.
  - Requester index constants REQ_PLAYER = 0 and REQ_MONSTER0..3 = 1..4.
  - The walkable-tile function.
- One sub-module: rr_pick. It is combinational: inputs req and rr_ptr, outputs a winner index and an any_req flag.

Test Plan:
- Single request, MAP_LAT=1: req = 00001 with (r,c) = (2,3) at T, map returns 010.
  - Required: gnt[0] and map_rd_en at T+1 with map_r = 2, map_c = 3; rsp_valid[0] at T+3, rsp_type = 010, rsp_walkable = 0.
- All five requests held high from T, map returns 011.
  - Required: rsp_valid pulses in order 0,1,2,3,4,0 at T+3, T+7, T+11, ...; rsp_walkable = 1 on each.
- Round-robin pointer: complete one query for requester 3, then assert req = 10011.
  - Required: next winner is 4, then 0, then 1.
- Request dropped early: req[2] high for one cycle only (T), map returns 001.
  - Required: gnt[2] at T+1 and rsp_valid[2] at T+3 with rsp_walkable = 1; no further gnt.
- Reset mid-transaction: assert rst during WAIT.
  - Required: all outputs 0 immediately, no rsp_valid afterwards, next request served from rr_ptr = 0.
- MAP_LAT=0 build: single request at T.
  - Required: map_rd_en at T+1, rsp_valid at T+2; MAP_LAT=3 build gives rsp_valid at T+5.
